// File: rtl/recip_scheduler.sv
// Round-robin scheduler that shares one reciprocal-counter core across four sensor
// channels: select, settle, wait for a result (or time out), then hold it for the consumer.
module recip_scheduler #(
  parameter int COARSE_WIDTH   = 24,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_fast,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [3:0]              ch_mask,
  output logic [1:0]              sel,
  output logic                    core_clr,
  input  logic                    core_busy,
  input  logic                    core_valid,
  input  logic [COARSE_WIDTH-1:0] core_coarse,
  output logic                    core_ack,
  output logic                    res_valid,
  input  logic                    res_ack,
  output logic [1:0]              res_ch,
  output logic [COARSE_WIDTH-1:0] res_coarse,
  output logic                    res_timeout,
  output logic                    sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_RESULT,
    S_ABORT
  } state_t;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [1:0]              r_rstSync;
  logic                    w_rstN;
  state_t                  r_state;
  state_t                  w_nextState;
  logic [1:0]              r_rrPtr;
  logic [1:0]              r_sel;
  logic [7:0]              r_settleCnt;
  logic [23:0]             r_tmoCnt;
  logic                    r_coreClr;
  logic                    r_coreAck;
  logic                    r_resValid;
  logic                    r_resTimeout;
  logic                    r_sweepDone;
  logic [1:0]              r_resCh;
  logic [COARSE_WIDTH-1:0] r_resCoarse;
  logic [3:0]              w_rot;
  logic [1:0]              w_off;
  logic [1:0]              w_pick;
  logic                    w_start;
  logic                    w_last;
  logic                    w_unusedBusy;

  // core_busy is status-only; the scheduler never depends on it
  assign w_unusedBusy = core_busy;

  // Async assert, clock-synchronous release of the internal reset
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) r_rstSync <= 2'b00;
    else        r_rstSync <= {r_rstSync[0], 1'b1};
  end
  assign w_rstN = r_rstSync[1];

  assign w_rot   = 4'({ch_mask, ch_mask} >> r_rrPtr);
  assign w_start = enable && (ch_mask != 4'b0000);
  assign w_pick  = r_rrPtr + w_off;

  always_comb begin
    w_off = 2'd0;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
  end

  // Pass is complete when no enabled channel sits above the current one
  always_comb begin
    w_last = 1'b1;
    case (r_sel)
      2'd0:    w_last = (ch_mask[3:1] == 3'b000);
      2'd1:    w_last = (ch_mask[3:2] == 2'b00);
      2'd2:    w_last = !ch_mask[3];
      default: w_last = 1'b1;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_nextState = S_SETTLE;
      S_SETTLE: if (r_settleCnt == SETTLE_LAST) w_nextState = S_WAIT;
      S_WAIT: begin
        if (core_valid)                   w_nextState = S_RESULT;
        else if (r_tmoCnt == TIMEOUT_LAST) w_nextState = S_ABORT;
      end
      S_ABORT:  w_nextState = S_RESULT;
      S_RESULT: if (res_ack) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fast or negedge w_rstN) begin
    if (!w_rstN) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  // A valid capture is checked before the timeout so it wins on the limit cycle
  always_ff @(posedge clk_fast or negedge w_rstN) begin
    if (!w_rstN) begin
      r_rrPtr      <= 2'd0;
      r_sel        <= 2'd0;
      r_settleCnt  <= 8'd0;
      r_tmoCnt     <= 24'd0;
      r_coreClr    <= 1'b0;
      r_coreAck    <= 1'b0;
      r_resValid   <= 1'b0;
      r_resTimeout <= 1'b0;
      r_sweepDone  <= 1'b0;
      r_resCh      <= 2'd0;
      r_resCoarse  <= '0;
    end else begin
      r_coreClr   <= 1'b0;
      r_coreAck   <= 1'b0;
      r_sweepDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sel       <= w_pick;
            r_coreClr   <= 1'b1;
            r_settleCnt <= 8'd0;
          end
        end
        S_SETTLE: begin
          if (r_settleCnt == SETTLE_LAST) r_tmoCnt    <= 24'd0;
          else                            r_settleCnt <= r_settleCnt + 8'd1;
        end
        S_WAIT: begin
          if (core_valid) begin
            r_resCoarse  <= core_coarse;
            r_resCh      <= r_sel;
            r_resTimeout <= 1'b0;
            r_resValid   <= 1'b1;
            r_coreAck    <= 1'b1;
          end else if (r_tmoCnt == TIMEOUT_LAST) begin
            r_coreClr <= 1'b1;
          end else begin
            r_tmoCnt <= r_tmoCnt + 24'd1;
          end
        end
        S_ABORT: begin
          r_resCoarse  <= '0;
          r_resCh      <= r_sel;
          r_resTimeout <= 1'b1;
          r_resValid   <= 1'b1;
        end
        S_RESULT: begin
          if (res_ack) begin
            r_resValid  <= 1'b0;
            r_rrPtr     <= r_sel + 2'd1;
            r_sweepDone <= w_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel         = r_sel;
  assign core_clr    = r_coreClr;
  assign core_ack    = r_coreAck;
  assign res_valid   = r_resValid;
  assign res_ch      = r_resCh;
  assign res_coarse  = r_resCoarse;
  assign res_timeout = r_resTimeout;
  assign sweep_done  = r_sweepDone;

endmodule

// File: tb/tb_recip_scheduler.sv
// Bench for recip_scheduler: a behavioural core and consumer drive the block while a
// scoreboard checks every presented result against hand-computed expectations.
module tb_recip_scheduler;
  localparam int CW     = 24;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  typedef struct packed {
    logic [1:0]    ch;
    logic [CW-1:0] coarse;
    logic          tmo;
  } exp_t;

  logic          clk_fast = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [3:0]    ch_mask;
  logic [1:0]    sel;
  logic          core_clr;
  logic          core_busy;
  logic          core_valid;
  logic [CW-1:0] core_coarse;
  logic          core_ack;
  logic          res_valid;
  logic          res_ack;
  logic [1:0]    res_ch;
  logic [CW-1:0] res_coarse;
  logic          res_timeout;
  logic          sweep_done;

  exp_t          expQ[$];
  exp_t          cur;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            clrCnt = 0;
  int            ackCnt = 0;
  int            sweepCnt = 0;
  int            resCnt = 0;
  int            clrCyc = 0;
  int            prevClrCyc = 0;
  int            coreDelay = -1;
  int            coreCnt = -1;
  logic [CW-1:0] coreCount = '0;
  int            ackHold = 2;
  int            ackWait = 0;
  bit            resSeen = 1'b0;

  recip_scheduler #(
    .COARSE_WIDTH(CW),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_fast(clk_fast),
    .rst_n(rst_n),
    .enable(enable),
    .ch_mask(ch_mask),
    .sel(sel),
    .core_clr(core_clr),
    .core_busy(core_busy),
    .core_valid(core_valid),
    .core_coarse(core_coarse),
    .core_ack(core_ack),
    .res_valid(res_valid),
    .res_ack(res_ack),
    .res_ch(res_ch),
    .res_coarse(res_coarse),
    .res_timeout(res_timeout),
    .sweep_done(sweep_done)
  );

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int delay, input logic [CW-1:0] count);
    ch_mask   = mask;
    coreDelay = delay;
    coreCount = count;
    enable    = 1'b1;
  endtask

  task automatic pushExp(input logic [1:0] ch, input logic [CW-1:0] coarse, input logic tmo);
    exp_t e;
    e.ch = ch;
    e.coarse = coarse;
    e.tmo = tmo;
    expQ.push_back(e);
  endtask

  task automatic waitClr(input int target, input string name);
    int n = 0;
    while (clrCnt < target && n < 3000) begin
      @(negedge clk_fast);
      n++;
    end
    total++;
    if (clrCnt < target) begin
      bad++;
      $display("[TB] FAIL %s: got %0d core_clr pulses expected %0d", name, clrCnt, target);
    end
  endtask

  task automatic waitRes(input int target, input string name);
    int n = 0;
    while (resCnt < target && n < 3000) begin
      @(negedge clk_fast);
      n++;
    end
    while (res_valid && n < 3000) begin
      @(negedge clk_fast);
      n++;
    end
    total++;
    if (resCnt < target || res_valid) begin
      bad++;
      $display("[TB] FAIL %s: got %0d results expected %0d", name, resCnt, target);
    end
    repeat (3) @(negedge clk_fast);
  endtask

  // Behavioural core: result appears coreDelay cycles after core_clr, drops on core_ack
  initial begin
    core_valid  = 1'b0;
    core_coarse = '0;
    core_busy   = 1'b0;
    forever begin
      @(negedge clk_fast);
      if (!rst_n) begin
        core_valid = 1'b0;
        coreCnt    = -1;
      end else if (core_clr) begin
        core_valid = 1'b0;
        coreCnt    = 0;
      end else if (core_ack) begin
        core_valid = 1'b0;
        coreCnt    = -1;
      end else if (coreCnt >= 0 && !core_valid) begin
        coreCnt++;
        if (coreDelay >= 0 && coreCnt == coreDelay) begin
          core_valid  = 1'b1;
          core_coarse = coreCount;
        end
      end
      core_busy = (coreCnt >= 0) && !core_valid;
    end
  end

  // Consumer: acknowledges each result ackHold cycles after it appears
  initial begin
    res_ack = 1'b0;
    forever begin
      @(negedge clk_fast);
      if (!rst_n) begin
        res_ack = 1'b0;
        ackWait = 0;
      end else if (res_valid && !res_ack) begin
        if (ackWait >= ackHold) begin
          res_ack = 1'b1;
          ackWait = 0;
        end else begin
          ackWait++;
        end
      end else begin
        res_ack = 1'b0;
      end
    end
  end

  always @(negedge clk_fast) begin
    if (core_clr) begin
      clrCnt++;
      prevClrCyc = clrCyc;
      clrCyc = cyc;
    end
    if (core_ack) ackCnt++;
    if (sweep_done) sweepCnt++;
  end

  // Scoreboard monitor
  always @(negedge clk_fast) begin
    if (res_valid && !resSeen) begin
      resSeen = 1'b1;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got ch=%0d coarse=%0d timeout=%0d expected no result",
                 res_ch, res_coarse, res_timeout);
      end else begin
        cur = expQ.pop_front();
        resCnt++;
        checkOutput("res_ch", 64'(res_ch), 64'(cur.ch));
        checkOutput("res_coarse", 64'(res_coarse), 64'(cur.coarse));
        checkOutput("res_timeout", 64'(res_timeout), 64'(cur.tmo));
      end
    end else if (res_valid) begin
      checkOutput("res_hold", 64'({res_ch, res_coarse, res_timeout}), 64'({cur.ch, cur.coarse, cur.tmo}));
    end else begin
      resSeen = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int ackBase;
    int swBase;
    rst_n   = 1'b0;
    enable  = 1'b0;
    ch_mask = 4'b0000;
    repeat (3) @(negedge clk_fast);
    checkOutput("reset_outputs", 64'({sel, core_clr, core_ack, res_valid, res_ch, res_coarse, res_timeout, sweep_done}), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_fast);
    checkOutput("idle_no_start", 64'(clrCnt), 64'd0);

    $display("[TB] two-channel pass, mask 0101");
    base = clrCnt; ackBase = ackCnt; swBase = sweepCnt;
    pushExp(2'd0, 24'd1000, 1'b0);
    pushExp(2'd2, 24'd1000, 1'b0);
    applyStimulus(4'b0101, 50, 24'd1000);
    waitClr(base + 2, "second_select");
    enable = 1'b0;
    waitRes(2, "pass_results");
    checkOutput("pass_core_ack", 64'(ackCnt - ackBase), 64'd2);
    checkOutput("pass_sweep", 64'(sweepCnt - swBase), 64'd1);
    checkOutput("pass_clr", 64'(clrCnt - base), 64'd2);

    $display("[TB] timeout with core silent");
    base = clrCnt; ackBase = ackCnt;
    pushExp(2'd0, 24'd0, 1'b1);
    applyStimulus(4'b0001, -1, 24'd0);
    waitClr(base + 1, "tmo_select");
    enable = 1'b0;
    waitRes(3, "tmo_result");
    checkOutput("tmo_clr", 64'(clrCnt - base), 64'd2);
    checkOutput("tmo_core_ack", 64'(ackCnt - ackBase), 64'd0);
    checkOutput("tmo_spacing", 64'(clrCyc - prevClrCyc), 64'(SETTLE + TMO));

    $display("[TB] valid on exact timeout cycle");
    base = clrCnt; ackBase = ackCnt;
    pushExp(2'd0, 24'd777, 1'b0);
    applyStimulus(4'b0001, SETTLE + TMO - 1, 24'd777);
    waitClr(base + 1, "edge_select");
    enable = 1'b0;
    waitRes(4, "edge_result");
    checkOutput("edge_core_ack", 64'(ackCnt - ackBase), 64'd1);
    checkOutput("edge_clr", 64'(clrCnt - base), 64'd1);

    $display("[TB] valid one cycle after timeout");
    base = clrCnt; ackBase = ackCnt;
    pushExp(2'd0, 24'd0, 1'b1);
    applyStimulus(4'b0001, SETTLE + TMO, 24'd888);
    waitClr(base + 1, "late_select");
    enable = 1'b0;
    waitRes(5, "late_result");
    checkOutput("late_core_ack", 64'(ackCnt - ackBase), 64'd0);
    checkOutput("late_clr", 64'(clrCnt - base), 64'd2);

    $display("[TB] consumer stalls acknowledge");
    base = clrCnt;
    ackHold = 200;
    pushExp(2'd1, 24'd555, 1'b0);
    pushExp(2'd0, 24'd555, 1'b0);
    applyStimulus(4'b0011, 10, 24'd555);
    waitClr(base + 1, "stall_select");
    for (int n = 0; n < 500 && !res_valid; n++) @(negedge clk_fast);
    repeat (150) @(negedge clk_fast);
    checkOutput("stall_valid", 64'(res_valid), 64'd1);
    checkOutput("stall_sel", 64'(sel), 64'd1);
    checkOutput("stall_no_clr", 64'(clrCnt - base), 64'd1);
    waitClr(base + 2, "stall_next");
    enable = 1'b0;
    checkOutput("stall_next_sel", 64'(sel), 64'd0);
    waitRes(7, "stall_results");
    ackHold = 2;

    $display("[TB] mask change during wait");
    base = clrCnt; swBase = sweepCnt;
    pushExp(2'd1, 24'd42, 1'b0);
    pushExp(2'd3, 24'd42, 1'b0);
    applyStimulus(4'b1111, 30, 24'd42);
    waitClr(base + 1, "mask_select");
    repeat (15) @(negedge clk_fast);
    checkOutput("mask_inflight_sel", 64'(sel), 64'd1);
    ch_mask = 4'b1000;
    waitClr(base + 2, "mask_next");
    enable = 1'b0;
    checkOutput("mask_next_sel", 64'(sel), 64'd3);
    waitRes(9, "mask_results");
    checkOutput("mask_sweep", 64'(sweepCnt - swBase), 64'd1);

    $display("[TB] reset during wait");
    base = clrCnt; ackBase = ackCnt;
    applyStimulus(4'b0110, -1, 24'd0);
    waitClr(base + 1, "rst_select");
    repeat (20) @(negedge clk_fast);
    checkOutput("rst_pre_sel", 64'(sel), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_immediate", 64'({sel, core_clr, core_ack, res_valid, res_ch, res_coarse, res_timeout, sweep_done}), 64'd0);
    pushExp(2'd0, 24'd9, 1'b0);
    applyStimulus(4'b1111, 5, 24'd9);
    repeat (3) @(negedge clk_fast);
    rst_n = 1'b1;
    @(posedge clk_fast);
    @(negedge clk_fast);
    checkOutput("rst_sync_first_edge", 64'(core_clr), 64'd0);
    waitClr(base + 2, "rst_restart");
    enable = 1'b0;
    checkOutput("rst_restart_sel", 64'(sel), 64'd0);
    waitRes(10, "rst_result");
    checkOutput("rst_core_ack", 64'(ackCnt - ackBase), 64'd1);

    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
